// File: rtl/hall_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hall_pkg
// Description : Shared definitions for the hall speed path (emulator and meter).
// Revision    : 1.0 - initial release
// ============================================================================
package hall_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_LOW  = 2'd2,
        ST_HIGH = 2'd3
    } hall_state_t;

    localparam int c_div_default   = 5000;
    localparam int c_scale_default = 10000;
    localparam int c_min_period    = 501;
    localparam int c_pulse_w       = 4;

    function automatic logic [15:0] clamp_period(input logic [15:0] quot,
                                                 input logic [15:0] min_p);
        return (quot < min_p) ? min_p : quot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hall_udiv16.sv
`default_nettype none
// ============================================================================
// Module      : hall_udiv16
// Description : Sequential restoring 16/16 unsigned divider, one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module hall_udiv16 (
    input  logic        clk0,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic        done
);

    logic [15:0] r_rem;
    logic [15:0] r_quo;
    logic [15:0] r_div;
    logic [4:0]  r_cnt;
    logic        r_done;
    logic [16:0] w_shift;
    logic [16:0] w_trial;

    assign w_shift = {r_rem, r_quo[15]};
    assign w_trial = w_shift - {1'b0, r_div};

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_rem <= '0;
                r_quo <= dividend;
                r_div <= divisor;
                r_cnt <= 5'd16;
            end else if (r_cnt != 5'd0) begin
                // Restore on borrow: keep the shifted remainder and shift in a 0.
                if (!w_trial[16]) begin
                    r_rem <= w_trial[15:0];
                    r_quo <= {r_quo[14:0], 1'b1};
                end else begin
                    r_rem <= w_shift[15:0];
                    r_quo <= {r_quo[14:0], 1'b0};
                end
                r_cnt <= r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign quotient = r_quo;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: rtl/hall_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : hall_pulse_gen
// Description : Hall-sensor emulator; speed word in, active-low tach pulses out.
// Revision    : 1.0 - initial release
// ============================================================================
module hall_pulse_gen
    import hall_pkg::*;
#(
    parameter int DIV        = c_div_default,
    parameter int SCALE      = c_scale_default,
    parameter int MIN_PERIOD = c_min_period,
    parameter int PULSE_W    = c_pulse_w
) (
    input  logic        clk0,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] speed,
    output logic        out_n,
    output logic [15:0] period,
    output logic [15:0] pulse_cnt,
    output logic        busy
);

    localparam int              c_pw         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_pw-1:0] c_presc_max  = c_pw'(DIV - 1);
    localparam logic [15:0]     c_scale      = 16'(SCALE);
    localparam logic [15:0]     c_min        = 16'(MIN_PERIOD);
    localparam logic [15:0]     c_pulse_last = 16'(PULSE_W - 1);

    logic [c_pw-1:0] r_presc;
    hall_state_t     r_state, w_state_n;
    logic            r_out_n, w_out_n_n;
    logic [15:0]     r_tcnt, w_tcnt_n;
    logic [15:0]     r_period, w_period_n;
    logic [15:0]     r_pulse_cnt, w_pulse_cnt_n;
    logic            r_ready, w_ready_n;
    logic            w_tick;
    logic            w_div_start;
    logic            w_div_done;
    logic [15:0]     w_quot;

    assign w_tick = (r_presc == c_presc_max);

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // The divider's divisor register doubles as the latched speed for the period.
    hall_udiv16 u_div (
        .clk0     (clk0),
        .rst_n    (rst_n),
        .start    (w_div_start),
        .dividend (c_scale),
        .divisor  (speed),
        .quotient (w_quot),
        .done     (w_div_done)
    );

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_n     <= 1'b1;
            r_tcnt      <= '0;
            r_period    <= '0;
            r_pulse_cnt <= '0;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_out_n     <= w_out_n_n;
            r_tcnt      <= w_tcnt_n;
            r_period    <= w_period_n;
            r_pulse_cnt <= w_pulse_cnt_n;
            r_ready     <= w_ready_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_out_n_n     = r_out_n;
        w_tcnt_n      = r_tcnt;
        w_period_n    = r_period;
        w_pulse_cnt_n = r_pulse_cnt;
        w_ready_n     = r_ready;
        w_div_start   = 1'b0;

        // Divider finishes well inside one tick, so done never coincides with a tick.
        if (r_state == ST_CALC && w_div_done) begin
            w_period_n = clamp_period(w_quot, c_min);
            w_ready_n  = 1'b1;
        end

        if (w_tick) begin
            if (!en) begin
                w_state_n = ST_IDLE;
                w_out_n_n = 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (speed != 16'd0) begin
                            w_div_start = 1'b1;
                            w_ready_n   = 1'b0;
                            w_state_n   = ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        if (r_ready) begin
                            w_state_n     = ST_LOW;
                            w_out_n_n     = 1'b0;
                            w_tcnt_n      = '0;
                            w_pulse_cnt_n = r_pulse_cnt + 16'd1;
                        end
                    end
                    ST_LOW: begin
                        w_tcnt_n = r_tcnt + 16'd1;
                        if (r_tcnt == c_pulse_last) begin
                            w_state_n = ST_HIGH;
                            w_out_n_n = 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        w_tcnt_n = r_tcnt + 16'd1;
                        // One tick early: CALC consumes the final tick of the period.
                        if (r_tcnt == r_period - 16'd2) begin
                            if (speed == 16'd0) begin
                                w_state_n  = ST_IDLE;
                                w_period_n = '0;
                            end else begin
                                w_div_start = 1'b1;
                                w_ready_n   = 1'b0;
                                w_state_n   = ST_CALC;
                            end
                        end
                    end
                    default: begin
                        w_state_n = ST_IDLE;
                        w_out_n_n = 1'b1;
                    end
                endcase
            end
        end
    end

    assign out_n     = r_out_n;
    assign period    = r_period;
    assign pulse_cnt = r_pulse_cnt;
    assign busy      = (r_state == ST_LOW) || (r_state == ST_HIGH);

endmodule
`default_nettype wire
